// File: rtl/mux_stream_arb.sv
// mux_stream_arb: N-channel registered stream multiplexer with valid/ready
// handshake. Selects one producer per cycle, either by an explicit channel
// index (manual mode) or round-robin among valid channels, and presents the
// chosen word on a single registered output with one cycle of latency.
module mux_stream_arb #(
   parameter  int N_CH  = 4,
   parameter  int WIDTH = 8,
   localparam int CH_W  = $clog2(N_CH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_CH*WIDTH-1:0] in_data,
   input  logic [N_CH-1:0]       in_valid,
   output logic [N_CH-1:0]       in_ready,
   input  logic                  mode,
   input  logic [CH_W-1:0]       sel,
   output logic [WIDTH-1:0]      out_data,
   output logic [CH_W-1:0]       out_chan,
   output logic                  out_valid,
   input  logic                  out_ready
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [CH_W-1:0]   rr_ptr;
   logic [CH_W-1:0]   rr_ptr_nxt;
   logic [CH_W-1:0]   gnt_idx;
   logic [CH_W-1:0]   rr_cand;
   logic [CH_W:0]     rr_sum;
   logic              rr_found;
   logic [N_CH-1:0]   grant;
   logic [WIDTH-1:0]  gnt_data;
   logic              load_en;
   logic              xfer;

   // The output register may take a new word when it is empty or being drained.
   assign out_valid = (state == FULL);
   assign load_en   = !out_valid | out_ready;

   // Arbitration: one-hot grant, only offered while the output can load.
   // Manual mode compares against every legal index, so an out-of-range sel
   // simply matches nothing. RR mode scans from rr_ptr with modulo wrap.
   always_comb begin
      grant    = '0;
      gnt_idx  = '0;
      rr_found = 1'b0;
      rr_sum   = '0;
      rr_cand  = '0;
      if (load_en) begin
         if (!mode) begin
            for (int i = 0; i < N_CH; i++) begin
               if (sel == CH_W'(i) && in_valid[i]) begin
                  grant[i] = 1'b1;
                  gnt_idx  = CH_W'(i);
               end
            end
         end else begin
            for (int k = 0; k < N_CH; k++) begin
               rr_sum = {1'b0, rr_ptr} + (CH_W+1)'(k);
               if (rr_sum >= (CH_W+1)'(N_CH)) begin
                  rr_sum = rr_sum - (CH_W+1)'(N_CH);
               end
               rr_cand = rr_sum[CH_W-1:0];
               for (int i = 0; i < N_CH; i++) begin
                  if (!rr_found && rr_cand == CH_W'(i) && in_valid[i]) begin
                     rr_found = 1'b1;
                     grant[i] = 1'b1;
                     gnt_idx  = CH_W'(i);
                  end
               end
            end
         end
      end
   end

   // Data steering for the granted channel and pointer advance past it.
   always_comb begin
      gnt_data = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (grant[i]) begin
            gnt_data = in_data[i*WIDTH +: WIDTH];
         end
      end
      rr_ptr_nxt = (gnt_idx == CH_W'(N_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
   end

   // Handshake: nothing is accepted while reset is asserted.
   assign in_ready = grant & {N_CH{rst_n}};
   assign xfer     = |(in_valid & in_ready);

   // Output register state: empty/full occupancy.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // Next occupancy: fill on a transfer, drain when consumed without refill.
   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY: if (xfer) state_nxt = FULL;
         FULL:  if (out_ready && !xfer) state_nxt = EMPTY;
         default: state_nxt = EMPTY;
      endcase
   end

   // Output word, source channel and RR pointer; held untouched unless a
   // transfer happens, so a stalled FULL word never changes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_data <= '0;
         out_chan <= '0;
         rr_ptr   <= '0;
      end else if (xfer) begin
         out_data <= gnt_data;
         out_chan <= gnt_idx;
         rr_ptr   <= rr_ptr_nxt;
      end
   end

endmodule

// File: tb/tb_mux_stream_arb.sv
// tb_mux_stream_arb: directed bench for mux_stream_arb with a 4-channel and a
// 6-channel instance; expected values are worked out by hand per step.
module tb_mux_stream_arb;

   logic        clk;
   logic        rst_n;

   logic [31:0] in_data;
   logic [3:0]  in_valid;
   logic [3:0]  in_ready;
   logic        mode;
   logic [1:0]  sel;
   logic [7:0]  out_data;
   logic [1:0]  out_chan;
   logic        out_valid;
   logic        out_ready;

   logic [47:0] in_data6;
   logic [5:0]  in_valid6;
   logic [5:0]  in_ready6;
   logic        mode6;
   logic [2:0]  sel6;
   logic [7:0]  out_data6;
   logic [2:0]  out_chan6;
   logic        out_valid6;
   logic        out_ready6;

   int n_checks = 0;
   int n_errors = 0;
   int exp_seq[4] = '{3, 1, 3, 1};

   mux_stream_arb #(.N_CH(4), .WIDTH(8)) dut4 (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .mode(mode), .sel(sel),
      .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
      .out_ready(out_ready)
   );

   mux_stream_arb #(.N_CH(6), .WIDTH(8)) dut6 (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data6), .in_valid(in_valid6), .in_ready(in_ready6),
      .mode(mode6), .sel(sel6),
      .out_data(out_data6), .out_chan(out_chan6), .out_valid(out_valid6),
      .out_ready(out_ready6)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic set_data4(input logic [7:0] base);
      for (int i = 0; i < 4; i++) in_data[i*8 +: 8] = base + 8'(i);
   endtask

   initial begin
      rst_n = 1'b0; mode = 1'b1; sel = '0; in_valid = 4'hF; out_ready = 1'b1;
      set_data4(8'h10);
      in_data6 = '0; in_valid6 = '0; mode6 = 1'b0; sel6 = '0; out_ready6 = 1'b1;

      // reset with all channels valid
      tick(); tick();
      chk("rst_in_ready", 32'(in_ready), 32'h0);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_out_data", 32'(out_data), 32'h0);
      chk("rst_out_chan", 32'(out_chan), 32'h0);
      chk("rst_out_valid6", 32'(out_valid6), 32'h0);

      // RR fairness, all valid: 0,1,2,3,0,1 back to back
      rst_n = 1'b1; #1;
      for (int k = 0; k < 6; k++) begin
         chk("rr_in_ready", 32'(in_ready), 32'(1 << (k % 4)));
         tick();
         chk("rr_valid", 32'(out_valid), 32'h1);
         chk("rr_chan", 32'(out_chan), 32'(k % 4));
         chk("rr_data", 32'(out_data), 32'(8'h10 + 8'(k % 4)));
      end

      // RR with only ch1/ch3 valid; pointer sits at 2 -> 3,1,3,1
      in_valid = 4'b1010;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("rr13_chan", 32'(out_chan), 32'(exp_seq[k]));
         chk("rr13_data", 32'(out_data), 32'(8'h10 + 8'(exp_seq[k])));
      end

      // backpressure: load 3C from ch2, then stall 5 cycles
      in_valid = 4'b0100; in_data[23:16] = 8'h3C;
      tick();
      chk("bp_load_data", 32'(out_data), 32'h3C);
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         in_valid = 4'hF;
         set_data4(8'h80 + 8'(k * 16));
         #1;
         chk("bp_in_ready", 32'(in_ready), 32'h0);
         tick();
         chk("bp_hold_data", 32'(out_data), 32'h3C);
         chk("bp_hold_chan", 32'(out_chan), 32'h2);
         chk("bp_hold_valid", 32'(out_valid), 32'h1);
      end
      out_ready = 1'b1; set_data4(8'h20); #1;
      chk("bp_release_ready", 32'(in_ready), 32'h8);
      tick();
      chk("bp_next_data", 32'(out_data), 32'h23);
      chk("bp_next_chan", 32'(out_chan), 32'h3);

      // wrap/skip: pointer 3 with only ch0 valid -> ch0, pointer 1
      in_valid = 4'b0100; set_data4(8'h40); #1;
      chk("wrap_pre_ready", 32'(in_ready), 32'h4);
      tick();
      in_valid = 4'b0001; set_data4(8'h50); #1;
      chk("wrap_ready", 32'(in_ready), 32'h1);
      tick();
      chk("wrap_data", 32'(out_data), 32'h50);
      chk("wrap_chan", 32'(out_chan), 32'h0);
      in_valid = 4'b0000;
      tick();
      chk("idle_drain_valid", 32'(out_valid), 32'h0);
      in_valid = 4'hF; #1;
      chk("ptr_held_ready", 32'(in_ready), 32'h2);

      // manual select on 4 channels
      mode = 1'b0; sel = 2'd2; set_data4(8'h10); in_data[23:16] = 8'hA5; #1;
      chk("man_ready", 32'(in_ready), 32'h4);
      tick();
      chk("man_data", 32'(out_data), 32'hA5);
      chk("man_chan", 32'(out_chan), 32'h2);
      sel = 2'd1; in_valid = 4'b1101; #1;
      chk("man_inv_ready", 32'(in_ready), 32'h0);
      tick();
      chk("man_inv_valid", 32'(out_valid), 32'h0);

      // manual select on 6 channels, including out-of-range sel
      for (int i = 0; i < 6; i++) in_data6[i*8 +: 8] = 8'h60 + 8'(i);
      in_valid6 = 6'h3F; sel6 = 3'd5; #1;
      chk("man6_ready", 32'(in_ready6), 32'h20);
      tick();
      chk("man6_data", 32'(out_data6), 32'h65);
      chk("man6_chan", 32'(out_chan6), 32'h5);
      sel6 = 3'd6; #1;
      chk("man6_oor_ready", 32'(in_ready6), 32'h0);
      tick();
      chk("man6_oor_valid", 32'(out_valid6), 32'h0);
      in_valid6 = '0;

      // reset mid-stream while FULL and stalled
      mode = 1'b1; in_valid = 4'b0010; out_ready = 1'b0; #1;
      chk("mid_fill_ready", 32'(in_ready), 32'h2);
      tick();
      chk("mid_full_valid", 32'(out_valid), 32'h1);
      chk("mid_full_data", 32'(out_data), 32'h11);
      in_valid = 4'hF; rst_n = 1'b0; #1;
      chk("mid_rst_ready", 32'(in_ready), 32'h0);
      tick();
      chk("mid_rst_valid", 32'(out_valid), 32'h0);
      chk("mid_rst_data", 32'(out_data), 32'h0);
      rst_n = 1'b1; out_ready = 1'b1; #1;
      chk("restart_ready", 32'(in_ready), 32'h1);
      tick();
      chk("restart_chan", 32'(out_chan), 32'h0);
      chk("restart_data", 32'(out_data), 32'h10);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
